// File: rtl/mem_arb_types.sv
// rtl/mem_arb_types.sv - arbiter states and priority mode constants
package mem_arb_types;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_DELIVER} ArbStates;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

endpackage

// File: rtl/top_level_types.sv
// rtl/top_level_types.sv - shared ISA core / memory port types
package top_level_types;

  typedef enum logic {me_rd, me_wr} ME_AccessType;
  typedef enum logic [1:0] {mt_b, mt_h, mt_w, mt_x} ME_MaskType;

  typedef struct packed {
    logic [31:0]  addrin;
    logic [31:0]  datain;
    ME_MaskType   mask;
    ME_AccessType req;
  } CUtoME_IF;

  typedef struct packed {
    logic [31:0] loadeddata;
  } MEtoCU_IF;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - two-way winner selection from the request notifies
module mem_arb_pick (
  input  logic notify0,
  input  logic notify1,
  input  logic last_grant,
  input  logic prio_mode,
  output logic grant_valid,
  output logic grant_idx
);

  always_comb begin
    grant_valid = notify0 | notify1;
    grant_idx   = 1'b0;
    // Ties go to whoever was not served last, unless master 0 is pinned as winner
    if (notify0 && notify1) begin
      grant_idx = prio_mode ? 1'b0 : ~last_grant;
    end else if (notify1) begin
      grant_idx = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between two masters, one transaction at a time
module mem_port_arbiter
  import top_level_types::*;
  import mem_arb_types::*;
#(
  parameter int PRIO_MODE = PRIO_RR
) (
  input  logic     clk,
  input  logic     rst,
  input  CUtoME_IF req0_in,
  input  logic     req0_in_notify,
  output logic     req0_in_sync,
  output MEtoCU_IF rsp0_out,
  input  logic     rsp0_out_notify,
  output logic     rsp0_out_sync,
  input  CUtoME_IF req1_in,
  input  logic     req1_in_notify,
  output logic     req1_in_sync,
  output MEtoCU_IF rsp1_out,
  input  logic     rsp1_out_notify,
  output logic     rsp1_out_sync,
  output CUtoME_IF mem_req,
  output logic     mem_req_notify,
  input  logic     mem_req_sync,
  input  MEtoCU_IF mem_rsp,
  output logic     mem_rsp_notify,
  input  logic     mem_rsp_sync,
  output logic     busy,
  output logic     owner
);

  ArbStates state, stateNext;
  logic     lastGrant;
  logic     grantValid;
  logic     grantIdx;
  logic     take;
  logic     ownerRspReady;

  mem_arb_pick uPick (
    .notify0    (req0_in_notify),
    .notify1    (req1_in_notify),
    .last_grant (lastGrant),
    .prio_mode  (PRIO_MODE == PRIO_FIXED),
    .grant_valid(grantValid),
    .grant_idx  (grantIdx)
  );

  // Requests are only accepted while idle; a waiting master stalls with notify held
  assign take          = (state == ARB_IDLE) && grantValid;
  assign req0_in_sync  = take && !grantIdx;
  assign req1_in_sync  = take && grantIdx;
  assign ownerRspReady = owner ? rsp1_out_notify : rsp0_out_notify;
  assign busy          = (state != ARB_IDLE);

  always_comb begin
    stateNext = state;
    case (state)
      ARB_IDLE:    if (grantValid)    stateNext = ARB_ISSUE;
      ARB_ISSUE:   if (mem_req_sync)  stateNext = ARB_WAIT;
      ARB_WAIT:    if (mem_rsp_sync)  stateNext = ARB_DELIVER;
      ARB_DELIVER: if (ownerRspReady) stateNext = ARB_IDLE;
      default:                        stateNext = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ARB_IDLE;
      mem_req        <= '{addrin: 32'h0, datain: 32'h0, mask: mt_w, req: me_rd};
      mem_req_notify <= 1'b0;
      mem_rsp_notify <= 1'b0;
      rsp0_out       <= '0;
      rsp1_out       <= '0;
      rsp0_out_sync  <= 1'b0;
      rsp1_out_sync  <= 1'b0;
      owner          <= 1'b0;
      lastGrant      <= 1'b1;
    end else begin
      state <= stateNext;
      case (state)
        ARB_IDLE: begin
          if (grantValid) begin
            mem_req        <= grantIdx ? req1_in : req0_in;
            mem_req_notify <= 1'b1;
            owner          <= grantIdx;
          end
        end
        ARB_ISSUE: begin
          if (mem_req_sync) begin
            mem_req_notify <= 1'b0;
            mem_rsp_notify <= 1'b1;
          end
        end
        ARB_WAIT: begin
          // Only the owner's response register is touched; the other keeps its last data
          if (mem_rsp_sync) begin
            mem_rsp_notify <= 1'b0;
            if (owner) begin
              rsp1_out      <= mem_rsp;
              rsp1_out_sync <= 1'b1;
            end else begin
              rsp0_out      <= mem_rsp;
              rsp0_out_sync <= 1'b1;
            end
          end
        end
        ARB_DELIVER: begin
          if (ownerRspReady) begin
            rsp0_out_sync <= 1'b0;
            rsp1_out_sync <= 1'b0;
            lastGrant     <= owner;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - bench for mem_port_arbiter, round-robin (dut 0) and fixed-priority (dut 1)
module tb_mem_port_arbiter;
  import top_level_types::*;

  localparam CUtoME_IF RST_REQ = '{addrin: 32'h0, datain: 32'h0, mask: mt_w, req: me_rd};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  CUtoME_IF reqIn     [2][2];
  logic     reqNotify [2][2];
  logic     reqSync   [2][2];
  MEtoCU_IF rspOut    [2][2];
  logic     rspNotify [2][2];
  logic     rspSync   [2][2];
  CUtoME_IF memReq       [2];
  logic     memReqNotify [2];
  logic     memReqSync   [2];
  MEtoCU_IF memRsp       [2];
  logic     memRspNotify [2];
  logic     memRspSync   [2];
  logic     busy         [2];
  logic     owner        [2];

  mem_port_arbiter #(.PRIO_MODE(0)) dutRr (
    .clk(clk), .rst(rst),
    .req0_in(reqIn[0][0]), .req0_in_notify(reqNotify[0][0]), .req0_in_sync(reqSync[0][0]),
    .rsp0_out(rspOut[0][0]), .rsp0_out_notify(rspNotify[0][0]), .rsp0_out_sync(rspSync[0][0]),
    .req1_in(reqIn[0][1]), .req1_in_notify(reqNotify[0][1]), .req1_in_sync(reqSync[0][1]),
    .rsp1_out(rspOut[0][1]), .rsp1_out_notify(rspNotify[0][1]), .rsp1_out_sync(rspSync[0][1]),
    .mem_req(memReq[0]), .mem_req_notify(memReqNotify[0]), .mem_req_sync(memReqSync[0]),
    .mem_rsp(memRsp[0]), .mem_rsp_notify(memRspNotify[0]), .mem_rsp_sync(memRspSync[0]),
    .busy(busy[0]), .owner(owner[0])
  );

  mem_port_arbiter #(.PRIO_MODE(1)) dutFx (
    .clk(clk), .rst(rst),
    .req0_in(reqIn[1][0]), .req0_in_notify(reqNotify[1][0]), .req0_in_sync(reqSync[1][0]),
    .rsp0_out(rspOut[1][0]), .rsp0_out_notify(rspNotify[1][0]), .rsp0_out_sync(rspSync[1][0]),
    .req1_in(reqIn[1][1]), .req1_in_notify(reqNotify[1][1]), .req1_in_sync(reqSync[1][1]),
    .rsp1_out(rspOut[1][1]), .rsp1_out_notify(rspNotify[1][1]), .rsp1_out_sync(rspSync[1][1]),
    .mem_req(memReq[1]), .mem_req_notify(memReqNotify[1]), .mem_req_sync(memReqSync[1]),
    .mem_rsp(memRsp[1]), .mem_rsp_notify(memRspNotify[1]), .mem_rsp_sync(memRspSync[1]),
    .busy(busy[1]), .owner(owner[1])
  );

  int checks = 0;
  int errors = 0;

  int          rspPct    [2][2];
  int          memReqPct [2];
  int          memRspPct [2];
  int          raisePct  [2];
  logic        fixData   [2];
  logic [31:0] fixWord   [2];
  CUtoME_IF    reqQ      [2][2][$];
  int          grantLog  [2][$];
  logic        fired     [2][2];

  // Transaction-level model: one transaction in flight, tracked by which handshake is still owed
  logic        mBusy [2];
  logic        mOwner [2];
  logic        mLast [2];
  logic        mReqPend [2];
  logic        mRspPend [2];
  logic        mDeliv [2];
  CUtoME_IF    mMemReq [2];
  logic [31:0] mData [2][2];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic CUtoME_IF mkReq(logic [31:0] a, logic [31:0] d, ME_MaskType mk, ME_AccessType rq);
    CUtoME_IF r;
    r.addrin = a;
    r.datain = d;
    r.mask   = mk;
    r.req    = rq;
    return r;
  endfunction

  // Dut 1 runs fixed priority, so master 0 takes every tie there
  function automatic logic expSync(int i, int m);
    logic w;
    if (mBusy[i] || !reqNotify[i][m]) return 1'b0;
    if (!reqNotify[i][1-m]) return 1'b1;
    w = (i == 1) ? 1'b0 : !mLast[i];
    return w == m[0];
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mBusy[i]    <= 1'b0;
        mOwner[i]   <= 1'b0;
        mLast[i]    <= 1'b1;
        mReqPend[i] <= 1'b0;
        mRspPend[i] <= 1'b0;
        mDeliv[i]   <= 1'b0;
        mMemReq[i]  <= RST_REQ;
        mData[i][0] <= 32'h0;
        mData[i][1] <= 32'h0;
      end else if (expSync(i, 0) || expSync(i, 1)) begin
        mBusy[i]    <= 1'b1;
        mReqPend[i] <= 1'b1;
        mOwner[i]   <= expSync(i, 1);
        mMemReq[i]  <= expSync(i, 1) ? reqIn[i][1] : reqIn[i][0];
      end else if (mReqPend[i] && memReqSync[i]) begin
        mReqPend[i] <= 1'b0;
        mRspPend[i] <= 1'b1;
      end else if (mRspPend[i] && memRspSync[i]) begin
        mRspPend[i] <= 1'b0;
        mDeliv[i]   <= 1'b1;
        mData[i][mOwner[i]] <= memRsp[i].loadeddata;
      end else if (mDeliv[i] && rspNotify[i][mOwner[i]]) begin
        mDeliv[i] <= 1'b0;
        mBusy[i]  <= 1'b0;
        mLast[i]  <= mOwner[i];
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("d%0d_req%0d_sync", i, m), 128'(reqSync[i][m]), 128'(expSync(i, m)));
        chk($sformatf("d%0d_rsp%0d_sync", i, m), 128'(rspSync[i][m]), 128'(mDeliv[i] && (mOwner[i] == m[0])));
        chk($sformatf("d%0d_rsp%0d_data", i, m), 128'(rspOut[i][m].loadeddata), 128'(mData[i][m]));
      end
      chk($sformatf("d%0d_mem_req_notify", i), 128'(memReqNotify[i]), 128'(mReqPend[i]));
      chk($sformatf("d%0d_mem_rsp_notify", i), 128'(memRspNotify[i]), 128'(mRspPend[i]));
      chk($sformatf("d%0d_busy", i), 128'(busy[i]), 128'(mBusy[i]));
      chk($sformatf("d%0d_owner", i), 128'(owner[i]), 128'(mOwner[i]));
      chk($sformatf("d%0d_mem_req", i), 128'(memReq[i]), 128'(mMemReq[i]));
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      for (int m = 0; m < 2; m++) begin
        fired[i][m] <= !rst && reqNotify[i][m] && reqSync[i][m];
        if (!rst && reqNotify[i][m] && reqSync[i][m]) grantLog[i].push_back(m);
      end
    end
  end

  // Masters and memory: drive just after each rising edge
  initial forever begin
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      for (int m = 0; m < 2; m++) begin
        if (rst) begin
          reqNotify[i][m] = 1'b0;
        end else begin
          if (fired[i][m]) begin
            reqNotify[i][m] = 1'b0;
            if (reqQ[i][m].size() > 0) void'(reqQ[i][m].pop_front());
          end
          if (!reqNotify[i][m] && reqQ[i][m].size() > 0 && int'($urandom_range(99)) < raisePct[i]) begin
            reqIn[i][m]     = reqQ[i][m][0];
            reqNotify[i][m] = 1'b1;
          end
        end
        rspNotify[i][m] = int'($urandom_range(99)) < rspPct[i][m];
      end
      memReqSync[i]        = int'($urandom_range(99)) < memReqPct[i];
      memRspSync[i]        = int'($urandom_range(99)) < memRspPct[i];
      memRsp[i].loadeddata = fixData[i] ? fixWord[i] : $urandom;
    end
  end

  task automatic waitGrant(input int i, input int m);
    int k = 0;
    while (!(reqNotify[i][m] && reqSync[i][m]) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("d%0d_grant%0d_timeout", i, m), 128'(k < 200), 128'(1));
  endtask

  task automatic waitIdle(input int i);
    int k = 0;
    while ((reqQ[i][0].size() + reqQ[i][1].size() != 0 || reqNotify[i][0] || reqNotify[i][1] || busy[i])
           && k < 6000) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("d%0d_idle_timeout", i), 128'(k < 6000), 128'(1));
  endtask

  task automatic waitMemRspNotify(input int i);
    int k = 0;
    while (!memRspNotify[i] && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("d%0d_wait_state_timeout", i), 128'(k < 200), 128'(1));
  endtask

  task automatic waitRspSync(input int i, input int m);
    int k = 0;
    while (!rspSync[i][m] && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("d%0d_rsp%0d_timeout", i, m), 128'(k < 200), 128'(1));
  endtask

  task automatic waitGrants(input int i, input int n);
    int k = 0;
    while (grantLog[i].size() < n && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("d%0d_grants_timeout", i), 128'(k < 400), 128'(1));
  endtask

  initial begin
    int base0, base1;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rspPct[i][0] = 100;
      rspPct[i][1] = 100;
      memReqPct[i] = 100;
      memRspPct[i] = 100;
      raisePct[i]  = 100;
      fixData[i]   = 1'b0;
      fixWord[i]   = 32'h0;
    end
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("d%0d_rst_busy", i), 128'(busy[i]), 128'(0));
      chk($sformatf("d%0d_rst_owner", i), 128'(owner[i]), 128'(0));
      chk($sformatf("d%0d_rst_mem_req", i), 128'(memReq[i]), 128'(RST_REQ));
      chk($sformatf("d%0d_rst_mem_req_notify", i), 128'(memReqNotify[i]), 128'(0));
    end

    // Simultaneous requests: round-robin alternates from master 0, fixed priority starves master 1
    for (int n = 0; n < 3; n++) begin
      reqQ[0][0].push_back(mkReq(32'h40 + n, 32'h0, mt_w, me_rd));
      reqQ[0][1].push_back(mkReq(32'h80 + n, 32'h0, mt_w, me_rd));
      reqQ[1][0].push_back(mkReq(32'hC0 + n, 32'h0, mt_w, me_rd));
    end
    reqQ[1][1].push_back(mkReq(32'hF0, 32'h0, mt_h, me_rd));
    waitGrants(0, 3);
    waitGrants(1, 3);
    chk("rr_grant0", 128'(grantLog[0][0]), 128'(0));
    chk("rr_grant1", 128'(grantLog[0][1]), 128'(1));
    chk("rr_grant2", 128'(grantLog[0][2]), 128'(0));
    chk("fx_grant0", 128'(grantLog[1][0]), 128'(0));
    chk("fx_grant1", 128'(grantLog[1][1]), 128'(0));
    chk("fx_grant2", 128'(grantLog[1][2]), 128'(0));
    chk("fx_m1_stalled", 128'(reqQ[1][1].size()), 128'(1));
    waitIdle(0);
    waitIdle(1);
    chk("fx_grant3", 128'(grantLog[1][3]), 128'(1));

    // Single read with zero-wait handshakes
    fixData[0] = 1'b1;
    fixWord[0] = 32'hDEADBEEF;
    reqQ[0][0].push_back(mkReq(32'h10, 32'h0, mt_w, me_rd));
    @(negedge clk);
    waitGrant(0, 0);
    @(negedge clk);
    chk("t1_mem_req_notify", 128'(memReqNotify[0]), 128'(1));
    chk("t1_addrin", 128'(memReq[0].addrin), 128'(32'h10));
    @(negedge clk);
    chk("t1_mem_rsp_notify", 128'(memRspNotify[0]), 128'(1));
    @(negedge clk);
    chk("t1_rsp_sync", 128'(rspSync[0][0]), 128'(1));
    chk("t1_rsp_data", 128'(rspOut[0][0].loadeddata), 128'(32'hDEADBEEF));
    @(negedge clk);
    chk("t1_busy_low", 128'(busy[0]), 128'(0));
    fixData[0] = 1'b0;

    // Store from master 1 arrives while master 0 waits on memory
    memRspPct[0] = 0;
    reqQ[0][0].push_back(mkReq(32'h14, 32'h0, mt_w, me_rd));
    waitMemRspNotify(0);
    reqQ[0][1].push_back(mkReq(32'h100, 32'h55, mt_b, me_wr));
    repeat (4) begin
      @(negedge clk);
      chk("t3_req1_stalled", 128'(reqSync[0][1]), 128'(0));
    end
    memRspPct[0] = 100;
    waitGrant(0, 1);
    @(negedge clk);
    chk("t3_store_on_mem", 128'(memReq[0]), 128'(mkReq(32'h100, 32'h55, mt_b, me_wr)));
    waitIdle(0);

    // Memory back-pressure on both phases
    memReqPct[1] = 0;
    reqQ[1][0].push_back(mkReq(32'h20, 32'h7, mt_w, me_rd));
    @(negedge clk);
    waitGrant(1, 0);
    repeat (5) begin
      @(negedge clk);
      chk("t4_issue_hold", 128'(memReqNotify[1]), 128'(1));
      chk("t4_issue_addr", 128'(memReq[1].addrin), 128'(32'h20));
    end
    memRspPct[1] = 0;
    memReqPct[1] = 100;
    waitMemRspNotify(1);
    repeat (3) begin
      @(negedge clk);
      chk("t4_wait_hold", 128'(memRspNotify[1]), 128'(1));
      chk("t4_wait_req_low", 128'(memReqNotify[1]), 128'(0));
    end
    memRspPct[1] = 100;
    waitIdle(1);

    // Master 0 is slow to take its response while master 1 waits
    rspPct[0][0] = 0;
    reqQ[0][0].push_back(mkReq(32'h24, 32'h0, mt_w, me_rd));
    @(negedge clk);
    waitGrant(0, 0);
    reqQ[0][1].push_back(mkReq(32'h28, 32'h0, mt_w, me_rd));
    waitRspSync(0, 0);
    repeat (4) begin
      @(negedge clk);
      chk("t5_rsp_held", 128'(rspSync[0][0]), 128'(1));
      chk("t5_req1_stalled", 128'(reqSync[0][1]), 128'(0));
    end
    rspPct[0][0] = 100;
    waitIdle(0);

    // Reset in the middle of a memory wait
    memRspPct[0] = 0;
    reqQ[0][0].push_back(mkReq(32'h2C, 32'h0, mt_w, me_rd));
    waitMemRspNotify(0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_mem_req_notify", 128'(memReqNotify[0]), 128'(0));
    chk("t6_rst_mem_rsp_notify", 128'(memRspNotify[0]), 128'(0));
    chk("t6_rst_rsp_sync", 128'({rspSync[0][0], rspSync[0][1]}), 128'(0));
    chk("t6_rst_mem_req", 128'(memReq[0]), 128'(RST_REQ));
    chk("t6_rst_busy", 128'(busy[0]), 128'(0));
    for (int i = 0; i < 2; i++) begin
      reqQ[i][0].delete();
      reqQ[i][1].delete();
    end
    memRspPct[0] = 100;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    fixData[0] = 1'b1;
    fixWord[0] = 32'h00001234;
    reqQ[0][0].push_back(mkReq(32'h30, 32'h0, mt_w, me_rd));
    @(negedge clk);
    waitGrant(0, 0);
    waitRspSync(0, 0);
    chk("t6_after_rst_data", 128'(rspOut[0][0].loadeddata), 128'(32'h00001234));
    waitIdle(0);
    fixData[0] = 1'b0;

    // Random traffic on both instances
    base0 = grantLog[0].size();
    base1 = grantLog[1].size();
    for (int i = 0; i < 2; i++) begin
      rspPct[i][0] = 30 + $urandom_range(70);
      rspPct[i][1] = 30 + $urandom_range(70);
      memReqPct[i] = 30 + $urandom_range(70);
      memRspPct[i] = 30 + $urandom_range(70);
      raisePct[i]  = 40 + $urandom_range(60);
      for (int m = 0; m < 2; m++) begin
        for (int n = 0; n < 30; n++) begin
          reqQ[i][m].push_back(mkReq($urandom, $urandom, ME_MaskType'(2'($urandom_range(3))),
                                     ME_AccessType'(1'($urandom_range(1)))));
        end
      end
    end
    waitIdle(0);
    waitIdle(1);
    chk("rand_d0_grants", 128'(grantLog[0].size() - base0), 128'(60));
    chk("rand_d1_grants", 128'(grantLog[1].size() - base1), 128'(60));

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
